// File: rtl/radar_pulse_meas.sv
// Pulse analyser: measures width/PRI of the pulse gate, captures per-pulse frequency word,
// and classifies CW / plain / stepped / hopping trains from a 4-deep frequency history.
`timescale 1ns/1ps
module radar_pulse_meas #(
  parameter int CNT_W = 26,
  parameter logic [CNT_W-1:0] CW_LIMIT  = CNT_W'(5_000_000),
  parameter logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(50_000_000)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             judge,
  input  logic             pulse_en,
  input  logic [31:0]      fw_in,
  output logic             pdw_valid,
  output logic [CNT_W-1:0] pdw_pw,
  output logic [CNT_W-1:0] pdw_pri,
  output logic [31:0]      pdw_fw,
  output logic [3:0]       mode_det,
  output logic [1:0]       pulse_idx,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_CW} state_t;

  localparam logic [3:0] MODE_CW    = 4'b0001;
  localparam logic [3:0] MODE_PLAIN = 4'b0010;
  localparam logic [3:0] MODE_STEP  = 4'b0100;
  localparam logic [3:0] MODE_HOP   = 4'b1000;

  state_t           state;
  logic             pen_d;
  logic [CNT_W-1:0] pw_cnt, pri_cnt, gap_cnt;
  logic [31:0]      fw_last;
  logic             pend_vld;
  logic [CNT_W-1:0] pend_pw;
  logic [31:0]      pend_fw;
  logic             first_pulse;
  logic [3:0][31:0] hist;
  logic [2:0]       hist_cnt;
  logic             cls_vld;

  logic rise, fall;
  assign rise = pulse_en & ~pen_d;
  assign fall = ~pulse_en & pen_d;
  assign busy = (state != S_IDLE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // hist[0] is the oldest entry; widened so 3*h0 and 4*h0 cannot wrap into a false match
  logic [33:0] h0_x1, h0_x2, h0_x3, h0_x4;
  logic        h0_nz, is_plain, is_step, is_hop;
  assign h0_x1 = {2'b00, hist[0]};
  assign h0_x2 = h0_x1 << 1;
  assign h0_x3 = h0_x2 + h0_x1;
  assign h0_x4 = h0_x1 << 2;
  assign h0_nz = |hist[0];
  assign is_plain = h0_nz && (hist[1] == hist[0]) && (hist[2] == hist[0]) && (hist[3] == hist[0]);
  assign is_step  = h0_nz && ({2'b00, hist[1]} == h0_x2) && ({2'b00, hist[2]} == h0_x3)
                          && ({2'b00, hist[3]} == h0_x4);
  assign is_hop   = h0_nz && ({2'b00, hist[1]} == h0_x3) && ({2'b00, hist[2]} == h0_x2)
                          && ({2'b00, hist[3]} == h0_x4);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;   pen_d <= 1'b0;      pw_cnt <= '0;   pri_cnt <= '0;  gap_cnt <= '0;
      fw_last <= '0;     pend_vld <= 1'b0;   pend_pw <= '0;  pend_fw <= '0;  first_pulse <= 1'b0;
      hist <= '0;        hist_cnt <= '0;     cls_vld <= 1'b0;
      pdw_valid <= 1'b0; pdw_pw <= '0;       pdw_pri <= '0;  pdw_fw <= '0;
      mode_det <= '0;    pulse_idx <= '0;
    end else if (judge) begin
      state <= S_IDLE;   pen_d <= 1'b0;      pw_cnt <= '0;   pri_cnt <= '0;  gap_cnt <= '0;
      fw_last <= '0;     pend_vld <= 1'b0;   pend_pw <= '0;  pend_fw <= '0;  first_pulse <= 1'b0;
      hist <= '0;        hist_cnt <= '0;     cls_vld <= 1'b0;
      pdw_valid <= 1'b0; pdw_pw <= '0;       pdw_pri <= '0;  pdw_fw <= '0;
      mode_det <= '0;    pulse_idx <= '0;
    end else begin
      pen_d     <= pulse_en;
      pdw_valid <= 1'b0;
      cls_vld   <= 1'b0;

      // Non-matching windows are expected between aligned groups; they only advance the index
      if (cls_vld) begin
        if (is_plain) begin
          mode_det <= MODE_PLAIN;
        end else if (is_step) begin
          mode_det  <= MODE_STEP;
          pulse_idx <= 2'd3;
        end else if (is_hop) begin
          mode_det  <= MODE_HOP;
          pulse_idx <= 2'd3;
        end else if (mode_det == MODE_STEP || mode_det == MODE_HOP) begin
          pulse_idx <= pulse_idx + 2'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (rise) begin
            state       <= S_HIGH;
            pw_cnt      <= CNT_W'(1);
            pri_cnt     <= CNT_W'(1);
            fw_last     <= fw_in;
            first_pulse <= 1'b0;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state    <= S_LOW;
            gap_cnt  <= CNT_W'(1);
            pend_vld <= 1'b1;
            pend_pw  <= pw_cnt;
            pend_fw  <= fw_last;
            hist     <= {fw_last, hist[3], hist[2], hist[1]};
            hist_cnt <= (hist_cnt == 3'd4) ? 3'd4 : hist_cnt + 3'd1;
            cls_vld  <= (hist_cnt >= 3'd3);
          end else begin
            fw_last <= fw_in;
            pri_cnt <= sat_inc(pri_cnt);
            if (sat_inc(pw_cnt) >= CW_LIMIT) begin
              state       <= S_CW;
              mode_det    <= MODE_CW;
              hist        <= '0;
              hist_cnt    <= '0;
              pend_vld    <= 1'b0;
              first_pulse <= 1'b1;
            end else begin
              pw_cnt <= sat_inc(pw_cnt);
            end
          end
        end
        S_LOW: begin
          if (rise) begin
            if (pend_vld && !first_pulse) begin
              pdw_valid <= 1'b1;
              pdw_pw    <= pend_pw;
              pdw_pri   <= sat_inc(pri_cnt);
              pdw_fw    <= pend_fw;
            end
            state       <= S_HIGH;
            pend_vld    <= 1'b0;
            first_pulse <= 1'b0;
            pri_cnt     <= CNT_W'(1);
            pw_cnt      <= CNT_W'(1);
            fw_last     <= fw_in;
          end else if (sat_inc(gap_cnt) >= GAP_LIMIT) begin
            state       <= S_IDLE;
            mode_det    <= '0;
            pulse_idx   <= '0;
            hist        <= '0;
            hist_cnt    <= '0;
            pend_vld    <= 1'b0;
            first_pulse <= 1'b1;
          end else begin
            pri_cnt <= sat_inc(pri_cnt);
            gap_cnt <= sat_inc(gap_cnt);
          end
        end
        default: begin
          if (fall) begin
            state   <= S_LOW;
            gap_cnt <= CNT_W'(1);
            pri_cnt <= CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radar_pulse_meas.sv
// Bench for radar_pulse_meas: event-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_radar_pulse_meas;
  localparam int CNT_W = 26;
  localparam logic [CNT_W-1:0] CW_LIM  = 26'd1000;
  localparam logic [CNT_W-1:0] GAP_LIM = 26'd2000;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic             sys_clk, sys_rst_n, judge, pulse_en;
  logic [31:0]      fw_in;
  logic             pdw_valid, busy;
  logic [CNT_W-1:0] pdw_pw, pdw_pri;
  logic [31:0]      pdw_fw;
  logic [3:0]       mode_det;
  logic [1:0]       pulse_idx;

  radar_pulse_meas #(.CNT_W(CNT_W), .CW_LIMIT(CW_LIM), .GAP_LIMIT(GAP_LIM)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .judge(judge), .pulse_en(pulse_en), .fw_in(fw_in),
    .pdw_valid(pdw_valid), .pdw_pw(pdw_pw), .pdw_pri(pdw_pri), .pdw_fw(pdw_fw),
    .mode_det(mode_det), .pulse_idx(pulse_idx), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0, failures = 0, dut_pdw_cnt = 0;
  bit chk_en = 1'b0;
  int idx_exp[5] = '{3, 0, 1, 2, 3};
  int step_m[4]  = '{1, 2, 3, 4};
  int hop_m[4]   = '{1, 3, 2, 4};
  logic [31:0] hop_seq[4] = '{32'd3000, 32'd2000, 32'd4000, 32'd1000};
  logic [31:0] ovf_seq[4] = '{32'h6000_0000, 32'hC000_0000, 32'h2000_0000, 32'h8000_0000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks runs of high/low samples, rise timestamps and a queue of pulse words
  logic        m_prev;
  bit          m_busy, m_cw, m_pend, m_cls_due;
  longint      m_hi_run, m_lo_run, m_pend_pw, m_last_rise, m_t;
  logic [31:0] m_cur_fw, m_pend_fw;
  logic [31:0] m_hist[$];
  bit          e_vld, e_busy;
  longint      e_pw, e_pri;
  logic [31:0] e_fw;
  logic [3:0]  e_mode;
  logic [1:0]  e_idx;

  function automatic void model_reset();
    m_prev = 1'b0; m_busy = 0; m_cw = 0; m_pend = 0; m_cls_due = 0;
    m_hi_run = 0; m_lo_run = 0; m_pend_pw = 0; m_last_rise = 0; m_cur_fw = '0; m_pend_fw = '0;
    m_hist.delete();
    e_vld = 0; e_busy = 0; e_pw = 0; e_pri = 0; e_fw = '0; e_mode = '0; e_idx = '0;
  endfunction

  function automatic void model_classify();
    longint a, b, c, d;
    a = longint'(m_hist[0]); b = longint'(m_hist[1]);
    c = longint'(m_hist[2]); d = longint'(m_hist[3]);
    if (a != 0 && b == a && c == a && d == a) e_mode = 4'b0010;
    else if (a != 0 && b == 2*a && c == 3*a && d == 4*a) begin e_mode = 4'b0100; e_idx = 2'd3; end
    else if (a != 0 && b == 3*a && c == 2*a && d == 4*a) begin e_mode = 4'b1000; e_idx = 2'd3; end
    else if (e_mode == 4'b0100 || e_mode == 4'b1000) e_idx = e_idx + 2'd1;
  endfunction

  function automatic void model_step(input logic p, input logic [31:0] f, input logic j);
    m_t++;
    e_vld = 0;
    if (j) begin model_reset(); return; end
    if (m_cls_due) begin m_cls_due = 0; model_classify(); end
    if (p && !m_prev) begin
      if (m_pend) begin
        e_vld = 1; e_pw = m_pend_pw; e_fw = m_pend_fw;
        e_pri = (m_t - m_last_rise > CNT_MAX) ? CNT_MAX : m_t - m_last_rise;
      end
      m_pend = 0; m_busy = 1; m_cw = 0; m_hi_run = 1; m_cur_fw = f; m_last_rise = m_t;
    end else if (p && m_prev) begin
      if (!m_cw) begin
        m_hi_run++; m_cur_fw = f;
        if (m_hi_run >= CW_LIM) begin
          m_cw = 1; e_mode = 4'b0001; m_hist.delete(); m_pend = 0;
        end
      end
    end else if (!p && m_prev) begin
      m_lo_run = 1;
      if (!m_cw) begin
        m_pend = 1; m_pend_pw = m_hi_run; m_pend_fw = m_cur_fw;
        m_hist.push_back(m_cur_fw);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4) m_cls_due = 1;
      end
      m_cw = 0;
    end else if (m_busy) begin
      m_lo_run++;
      if (m_lo_run >= GAP_LIM) begin
        m_busy = 0; e_mode = '0; e_idx = '0; m_hist.delete(); m_pend = 0;
      end
    end
    m_prev = p;
    e_busy = m_busy;
  endfunction

  always @(negedge sys_clk) begin
    if (chk_en && sys_rst_n) begin
      chk("pdw_valid", pdw_valid, e_vld);
      chk("pdw_pw", pdw_pw, e_pw);
      chk("pdw_pri", pdw_pri, e_pri);
      chk("pdw_fw", pdw_fw, e_fw);
      chk("mode_det", mode_det, e_mode);
      chk("busy", busy, e_busy);
      if (e_mode == 4'b0100 || e_mode == 4'b1000) chk("pulse_idx", pulse_idx, e_idx);
      if (pdw_valid === 1'b1) dut_pdw_cnt++;
    end
  end

  task automatic cyc(input logic p, input logic [31:0] f, input logic j);
    pulse_en = p; fw_in = f; judge = j;
    @(posedge sys_clk);
    model_step(p, f, j);
    @(negedge sys_clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, pdw_valid, 0);
    chk({tag, "_pw"}, pdw_pw, 0);
    chk({tag, "_pri"}, pdw_pri, 0);
    chk({tag, "_fw"}, pdw_fw, 0);
    chk({tag, "_mode"}, mode_det, 0);
    chk({tag, "_idx"}, pulse_idx, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  int kind, np, hi, lo, start, n0;
  logic [31:0] base, f;

  initial begin
    sys_rst_n = 1'b0; pulse_en = 1'b0; fw_in = '0; judge = 1'b0;
    m_t = 0;
    model_reset();
    @(negedge sys_clk);
    chk_zero("reset");
    #1 sys_rst_n = 1'b1;
    chk_en = 1'b1;

    // Plain train 100 high / 400 low, then loss of train
    n0 = dut_pdw_cnt;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 32'd1000, 1'b0);
      if (i > 0) begin
        chk("plain_vld", pdw_valid, 1); chk("plain_pw", pdw_pw, 100);
        chk("plain_pri", pdw_pri, 500); chk("plain_fw", pdw_fw, 1000);
      end
      repeat (99) cyc(1'b1, 32'd1000, 1'b0);
      cyc(1'b0, 32'd1000, 1'b0);
      if (i == 3) chk("plain_mode_pre", mode_det, 4'b0000);
      cyc(1'b0, 32'd1000, 1'b0);
      if (i == 3) chk("plain_mode", mode_det, 4'b0010);
      if (i < 5) repeat (398) cyc(1'b0, 32'd1000, 1'b0);
    end
    chk("plain_pdw_count", dut_pdw_cnt - n0, 5);
    repeat (1997) cyc(1'b0, 32'd0, 1'b0);
    chk("gap_busy_pre", busy, 1);
    cyc(1'b0, 32'd0, 1'b0);
    chk("gap_busy", busy, 0);
    chk("gap_mode", mode_det, 4'b0000);

    // Stepped train
    for (int i = 0; i < 8; i++) begin
      f = 32'd1000 * (i % 4 + 1);
      repeat (10) cyc(1'b1, f, 1'b0);
      cyc(1'b0, f, 1'b0);
      cyc(1'b0, f, 1'b0);
      if (i >= 3) begin
        chk("step_mode", mode_det, 4'b0100);
        chk("step_idx", pulse_idx, idx_exp[i-3]);
      end
      repeat (18) cyc(1'b0, f, 1'b0);
    end

    // Hopping train starting mid-sequence, judge mid-high on the last pulse
    cyc(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      f = hop_seq[i % 4];
      if (i == 7) begin
        repeat (5) cyc(1'b1, f, 1'b0);
        cyc(1'b1, f, 1'b1);
        chk_zero("judge");
        cyc(1'b0, f, 1'b0);
      end else begin
        repeat (10) cyc(1'b1, f, 1'b0);
        cyc(1'b0, f, 1'b0);
        cyc(1'b0, f, 1'b0);
        if (i == 5) chk("hop_mode_pre", mode_det, 4'b0000);
        if (i == 6) begin chk("hop_mode", mode_det, 4'b1000); chk("hop_idx", pulse_idx, 3); end
        repeat (18) cyc(1'b0, f, 1'b0);
      end
    end

    // Continuous wave, then two ordinary pulses
    repeat (5) cyc(1'b0, 32'd0, 1'b0);
    n0 = dut_pdw_cnt;
    repeat (999) cyc(1'b1, 32'd5555, 1'b0);
    chk("cw_mode_pre", mode_det, 4'b0000);
    cyc(1'b1, 32'd5555, 1'b0);
    chk("cw_mode", mode_det, 4'b0001);
    chk("cw_busy", busy, 1);
    repeat (50) cyc(1'b1, 32'd5555, 1'b0);
    repeat (20) cyc(1'b0, 32'd0, 1'b0);
    repeat (2) begin
      repeat (10) cyc(1'b1, 32'd700, 1'b0);
      repeat (20) cyc(1'b0, 32'd700, 1'b0);
    end
    chk("cw_pdw_count", dut_pdw_cnt - n0, 1);
    chk("cw_pw", pdw_pw, 10); chk("cw_pri", pdw_pri, 30); chk("cw_fw", pdw_fw, 700);

    // One-cycle pulses with period 3, then async reset mid-low
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'd77, 1'b0);
      if (i > 0) begin
        chk("glitch_vld", pdw_valid, 1); chk("glitch_pw", pdw_pw, 1);
        chk("glitch_pri", pdw_pri, 3); chk("glitch_fw", pdw_fw, 77);
      end
      cyc(1'b0, 32'd77, 1'b0);
      cyc(1'b0, 32'd77, 1'b0);
    end
    #2 sys_rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    @(posedge sys_clk);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Window that only matches stepped if 3*h0 and 4*h0 wrap at 32 bits
    for (int i = 0; i < 4; i++) begin
      repeat (5) cyc(1'b1, ovf_seq[i], 1'b0);
      cyc(1'b0, 32'd0, 1'b0);
      cyc(1'b0, 32'd0, 1'b0);
      repeat (8) cyc(1'b0, 32'd0, 1'b0);
    end
    chk("ovf_mode", mode_det, 4'b0000);

    // Randomized bursts
    for (int b = 0; b < 30; b++) begin
      kind  = $urandom_range(0, 5);
      np    = $urandom_range(1, 9);
      start = $urandom_range(0, 3);
      base  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
      if (kind == 4) begin
        hi = $urandom_range(995, 1005);
        repeat (hi) cyc(1'b1, $urandom, 1'b0);
        repeat ($urandom_range(1, 40)) cyc(1'b0, $urandom, 1'b0);
      end else if (kind == 5) begin
        cyc(1'($urandom_range(0, 1)), $urandom, 1'b1);
      end else begin
        for (int k = 0; k < np; k++) begin
          hi = $urandom_range(1, 20);
          lo = $urandom_range(1, 30);
          case (kind)
            0:       f = base;
            1:       f = base * step_m[(start + k) % 4];
            2:       f = base * hop_m[(start + k) % 4];
            default: f = $urandom;
          endcase
          for (int c = 0; c < hi; c++) cyc(1'b1, (kind == 3) ? $urandom : f, 1'b0);
          repeat (lo) cyc(1'b0, $urandom, 1'b0);
        end
      end
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1995, 2005)) cyc(1'b0, $urandom, 1'b0);
    end

    repeat (3) cyc(1'b0, 32'd0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
